// File: rtl/ball_pkg.sv
// Shared types for the ball motion datapath: direction encoding, scheduler
// states, USB keycodes for W/A/S/D and direction helpers.
package ball_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_ISSUE = 2'd2
  } sched_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      default:   r = DIR_NONE;
    endcase
    return r;
  endfunction

  function automatic dir_t key_decode(input logic [7:0] b);
    dir_t r;
    case (b)
      KEY_W:   r = DIR_UP;
      KEY_A:   r = DIR_LEFT;
      KEY_S:   r = DIR_DOWN;
      KEY_D:   r = DIR_RIGHT;
      default: r = DIR_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and emits a
// registered single-cycle pulse on each rising edge.
module frame_tick_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic [SYNC_STG-1:0] sync_r;
  logic                last_r;
  logic                tick_r;

  // synchronizer chain, edge history and registered rising-edge pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_r <= {SYNC_STG{1'b0}};
      last_r <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STG-2:0], frame_clk};
      last_r <= sync_r[SYNC_STG-1];
      tick_r <= sync_r[SYNC_STG-1] & ~last_r;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/ball_dir_scheduler.sv
// Per-frame direction scheduler: picks one ball direction per frame tick and
// offers it over cmd_valid/cmd_ready. Define BALL_NO_REVERSE_EN to block key reversals.
module ball_dir_scheduler
  import ball_pkg::*;
#(
  parameter int OVR_W    = 8,
  parameter int SYNC_STG = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic [15:0]      keycode,
  input  logic [3:0]       edge_hit,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_dir,
  output logic [2:0]       cur_dir,
  output logic [OVR_W-1:0] overrun_cnt
);

  logic         tick_s;
  sched_state_t state_r;
  logic [15:0]  key_cap_r;
  logic [3:0]   edge_cap_r;
  logic         new0_r;
  logic         new1_r;
  logic [7:0]   prev0_r;
  logic [7:0]   prev1_r;
  logic         cmd_valid_r;
  dir_t         cmd_dir_r;
  dir_t         cur_dir_r;
  logic [OVR_W-1:0] ovr_r;

  dir_t raw0_s;
  dir_t raw1_s;
  dir_t slot0_s;
  dir_t slot1_s;
  dir_t win_s;
  logic wall_s;
  logic issue_s;

  frame_tick_sync #(.SYNC_STG(SYNC_STG)) u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick_s)
  );

  // slot decode and winner arbitration over the captured frame snapshot
  always_comb begin
    raw0_s = key_decode(key_cap_r[7:0]);
    raw1_s = key_decode(key_cap_r[15:8]);
`ifdef BALL_NO_REVERSE_EN
    slot0_s = (raw0_s == opposite(cur_dir_r)) ? DIR_NONE : raw0_s;
    slot1_s = (raw1_s == opposite(cur_dir_r)) ? DIR_NONE : raw1_s;
`else
    slot0_s = raw0_s;
    slot1_s = raw1_s;
`endif
    win_s  = DIR_NONE;
    wall_s = 1'b1;
    if (edge_cap_r[3]) begin
      win_s = DIR_UP;
    end else if (edge_cap_r[2]) begin
      win_s = DIR_DOWN;
    end else if (edge_cap_r[1]) begin
      win_s = DIR_LEFT;
    end else if (edge_cap_r[0]) begin
      win_s = DIR_RIGHT;
    end else begin
      wall_s = 1'b0;
      if ((slot0_s != DIR_NONE) && new0_r) begin
        win_s = slot0_s;
      end else if ((slot1_s != DIR_NONE) && new1_r) begin
        win_s = slot1_s;
      end else if ((cur_dir_r != DIR_NONE) &&
                   ((slot0_s == cur_dir_r) || (slot1_s == cur_dir_r))) begin
        win_s = cur_dir_r;
      end else if (slot0_s != DIR_NONE) begin
        win_s = slot0_s;
      end else if (slot1_s != DIR_NONE) begin
        win_s = slot1_s;
      end else begin
        win_s = DIR_NONE;
      end
    end
    // a wall contact always reissues so the ball bounces even on the same heading
    issue_s = wall_s | ((win_s != DIR_NONE) && (win_s != cur_dir_r));
  end

  // scheduler FSM, frame capture, command register and overrun counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      key_cap_r   <= 16'h0000;
      edge_cap_r  <= 4'h0;
      new0_r      <= 1'b0;
      new1_r      <= 1'b0;
      prev0_r     <= 8'h00;
      prev1_r     <= 8'h00;
      cmd_valid_r <= 1'b0;
      cmd_dir_r   <= DIR_NONE;
      cur_dir_r   <= DIR_NONE;
      ovr_r       <= {OVR_W{1'b0}};
    end else begin
      if (tick_s && (state_r != ST_IDLE) && (ovr_r != {OVR_W{1'b1}})) begin
        ovr_r <= ovr_r + {{(OVR_W-1){1'b0}}, 1'b1};
      end
      case (state_r)
        ST_IDLE: begin
          if (tick_s) begin
            key_cap_r  <= keycode;
            edge_cap_r <= edge_hit;
            new0_r     <= (keycode[7:0]  != prev0_r);
            new1_r     <= (keycode[15:8] != prev1_r);
            prev0_r    <= keycode[7:0];
            prev1_r    <= keycode[15:8];
            state_r    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (issue_s) begin
            cmd_valid_r <= 1'b1;
            cmd_dir_r   <= win_s;
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cur_dir_r   <= cmd_dir_r;
            cmd_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          cmd_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_r;
  assign cmd_dir     = cmd_dir_r;
  assign cur_dir     = cur_dir_r;
  assign overrun_cnt = ovr_r;

endmodule

// File: tb/tb_ball_dir_scheduler.sv
// Directed plus randomized frames for ball_dir_scheduler, checked against a
// priority-list reference model of the direction rules.
module tb_ball_dir_scheduler;
  import ball_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic [3:0]  edge_hit = 4'h0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [2:0]  cmd_dir;
  logic [2:0]  cur_dir;
  logic [7:0]  overrun_cnt;

  int checks = 0;
  int failures = 0;

  dir_t       m_cur = DIR_NONE;
  logic [7:0] m_prev0 = 8'h00;
  logic [7:0] m_prev1 = 8'h00;
  int         m_ovr = 0;
  bit         last_iss;
  dir_t       last_dir;

  ball_dir_scheduler #(.OVR_W(8), .SYNC_STG(2)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .edge_hit    (edge_hit),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_dir     (cmd_dir),
    .cur_dir     (cur_dir),
    .overrun_cnt (overrun_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dir_t key_of(input logic [7:0] b);
    if (b == 8'h1A) return DIR_UP;
    if (b == 8'h04) return DIR_LEFT;
    if (b == 8'h16) return DIR_DOWN;
    if (b == 8'h07) return DIR_RIGHT;
    return DIR_NONE;
  endfunction

  function automatic bit reverses(input dir_t a, input dir_t b);
    return (a == DIR_UP && b == DIR_DOWN) || (a == DIR_DOWN && b == DIR_UP) ||
           (a == DIR_LEFT && b == DIR_RIGHT) || (a == DIR_RIGHT && b == DIR_LEFT);
  endfunction

  // Reference: walk the priority list of candidates for one frame
  task automatic model_frame(input logic [15:0] kc, input logic [3:0] eh,
                             output bit iss, output dir_t d);
    dir_t       k[2];
    bit         fresh[2];
    logic [7:0] byt[2];
    dir_t       wall_dir[4];
    wall_dir = '{DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP};
    byt[0] = kc[7:0];
    byt[1] = kc[15:8];
    fresh[0] = (byt[0] != m_prev0);
    fresh[1] = (byt[1] != m_prev1);
    for (int i = 0; i < 2; i++) begin
      k[i] = key_of(byt[i]);
`ifdef BALL_NO_REVERSE_EN
      if (reverses(k[i], m_cur)) k[i] = DIR_NONE;
`endif
    end
    for (int b = 3; b >= 0; b--) begin
      if (eh[b]) begin
        iss = 1'b1;
        d = wall_dir[b];
        return;
      end
    end
    d = DIR_NONE;
    for (int i = 0; i < 2; i++)
      if (d == DIR_NONE && k[i] != DIR_NONE && fresh[i]) d = k[i];
    if (d == DIR_NONE && m_cur != DIR_NONE && (k[0] == m_cur || k[1] == m_cur)) d = m_cur;
    for (int i = 0; i < 2; i++)
      if (d == DIR_NONE && k[i] != DIR_NONE) d = k[i];
    iss = (d != DIR_NONE) && (d != m_cur);
  endtask

  task automatic frame(input string tag, input logic [15:0] kc, input logic [3:0] eh,
                       input logic rdy);
    bit   iss;
    dir_t d;
    model_frame(kc, eh, iss, d);
    m_prev0 = kc[7:0];
    m_prev1 = kc[15:8];
    @(negedge Clk);
    keycode = kc;
    edge_hit = eh;
    cmd_ready = rdy;
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    check({tag, "/early"}, cmd_valid, 32'd0);
    @(negedge Clk);
    check({tag, "/valid"}, cmd_valid, iss);
    if (iss) check({tag, "/dir"}, cmd_dir, d);
    if (iss && rdy) begin
      @(negedge Clk);
      check({tag, "/ack_valid"}, cmd_valid, 32'd0);
      m_cur = d;
    end
    check({tag, "/cur"}, cur_dir, m_cur);
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
    check({tag, "/ovr"}, overrun_cnt, m_ovr);
    last_iss = iss;
    last_dir = d;
  endtask

  task automatic drop_frame(input string tag);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (8) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
    m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
    check({tag, "/valid"}, cmd_valid, 32'd1);
    check({tag, "/dir"}, cmd_dir, last_dir);
    check({tag, "/ovr"}, overrun_cnt, m_ovr);
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h1A;
      2: return 8'h04;
      3: return 8'h16;
      4: return 8'h07;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge Clk);
    check("rst/valid", cmd_valid, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst/cmd_dir", cmd_dir, DIR_NONE);
    check("rst/cur", cur_dir, DIR_NONE);
    check("rst/ovr", overrun_cnt, 32'd0);

    for (int i = 0; i < 3; i++) frame("idle", 16'h0000, 4'h0, 1'b1);
    frame("press_w", 16'h001A, 4'h0, 1'b1);
    check("press_w/is_up", cur_dir, DIR_UP);
    frame("hold_w", 16'h001A, 4'h0, 1'b1);
    frame("new_d", 16'h071A, 4'h0, 1'b1);
    check("new_d/is_right", cur_dir, DIR_RIGHT);
    frame("hold_d", 16'h071A, 4'h0, 1'b1);
    frame("wall_r", 16'h0007, 4'b0010, 1'b1);
    check("wall_r/is_left", cur_dir, DIR_LEFT);
    frame("wall_b", 16'h0000, 4'b1000, 1'b1);
    frame("wall_same", 16'h0000, 4'b1000, 1'b1);
    frame("reverse", 16'h0016, 4'h0, 1'b1);
`ifdef BALL_NO_REVERSE_EN
    check("reverse/blocked", cur_dir, DIR_UP);
`else
    check("reverse/taken", cur_dir, DIR_DOWN);
`endif

    // stalled command: further frames are dropped and counted
    frame("stall", 16'h0000, 4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) drop_frame("drop");
    check("stall/ovr5", overrun_cnt, 32'd5);
    @(negedge Clk);
    cmd_ready = 1'b1;
    @(negedge Clk);
    check("release/valid", cmd_valid, 32'd0);
    check("release/cur", cur_dir, last_dir);
    m_cur = last_dir;

    // reset while a command is pending
    frame("pend", 16'h0000, 4'b0100, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("rst_mid/valid", cmd_valid, 32'd0);
    check("rst_mid/cur", cur_dir, DIR_NONE);
    check("rst_mid/ovr", overrun_cnt, 32'd0);
    m_cur = DIR_NONE;
    m_prev0 = 8'h00;
    m_prev1 = 8'h00;
    m_ovr = 0;

    for (int i = 0; i < 60; i++) begin
      logic [15:0] kc;
      logic [3:0]  eh;
      kc = {pick_byte(), pick_byte()};
      eh = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      frame("rand", kc, eh, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
